// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file requester: FSM states and
// default geometry of the 2-port, 4-entry register file.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RSP
    } state_t;

    localparam int RF_ADDR_W = 2;
    localparam int RF_DATA_W = 8;
    localparam int RF_RD_LAT = 2;

endpackage

// File: rtl/regfile_requester.sv
// Register-file requester: turns a valid/ready read/write request stream
// into register-file port activity and returns read data on a valid/ready
// response stream.
// Optional feature: define REGFILE_REQUESTER_WRITE_ACK_EN so that writes
// also produce an acknowledge response (rsp_write = 1).
module regfile_requester
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W,
    parameter int RD_LAT = RF_RD_LAT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_write,
    output logic [ADDR_W-1:0] rf_write_address,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_read_address,
    input  logic [DATA_W-1:0] rf_read_data
);

    localparam int CNT_W = $clog2(RD_LAT) + 1;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;

    // Requests are only taken while no read or response is outstanding.
    always_comb begin
        req_ready = (state == IDLE);
    end

    // Request FSM with registered register-file and response outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
            rsp_write        <= 1'b0;
            rf_write_en      <= 1'b0;
            rf_write_address <= '0;
            rf_write_data    <= '0;
            rf_read_address  <= '0;
        end else begin
            rf_write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_write) begin
                            rf_write_address <= req_addr;
                            rf_write_data    <= req_wdata;
                            rf_write_en      <= 1'b1;
`ifdef REGFILE_REQUESTER_WRITE_ACK_EN
                            rsp_valid        <= 1'b1;
                            rsp_write        <= 1'b1;
                            rsp_rdata        <= req_wdata;
                            state            <= RSP;
`endif
                        end else begin
                            rf_read_address <= req_addr;
                            wait_cnt        <= CNT_W'(RD_LAT - 1);
                            state           <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    // Counter stops at zero; data is sampled on that edge.
                    if (wait_cnt == '0) begin
                        rsp_rdata <= rf_read_data;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        state     <= RSP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_requester.sv
// Self-checking bench for regfile_requester with a behavioural register
// file and a transaction-level reference model.
module tb_regfile_requester;
    import regfile_pkg::*;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int LAT = 2;

    logic          clock;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_write;
    logic [AW-1:0] rf_write_address;
    logic [DW-1:0] rf_write_data;
    logic          rf_write_en;
    logic [AW-1:0] rf_read_address;
    logic [DW-1:0] rf_read_data;

    int passes = 0;
    int checks = 0;

    regfile_requester #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .rsp_write        (rsp_write),
        .rf_write_address (rf_write_address),
        .rf_write_data    (rf_write_data),
        .rf_write_en      (rf_write_en),
        .rf_read_address  (rf_read_address),
        .rf_read_data     (rf_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural register file: one registered read stage, so data for a
    // new address appears one edge after the address changes.
    logic [DW-1:0] rf_mem [4];
    always @(posedge clock) begin
        if (rf_write_en) rf_mem[rf_write_address] <= rf_write_data;
        rf_read_data <= rf_mem[rf_read_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            passes++;
    endtask

    // Transaction-level reference model, advanced at each rising edge.
    logic [DW-1:0] ref_mem [4];
    bit            m_live = 0;
    bit            m_busy, m_rsp, m_wack, exp_we;
    int            m_cnt;
    logic [DW-1:0] m_data, exp_wdata;
    logic [AW-1:0] exp_waddr, exp_raddr;

    always @(posedge clock) begin
        bit ready_pre, rsp_pre;
        if (!reset_n) begin
            m_busy = 0; m_rsp = 0; m_wack = 0; m_cnt = 0; exp_we = 0;
            exp_waddr = '0; exp_wdata = '0; exp_raddr = '0; m_data = '0;
            m_live = 1;
        end else begin
            ready_pre = !m_busy;
            rsp_pre   = m_rsp;
            exp_we    = 0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_rsp = 1; m_data = ref_mem[exp_raddr]; m_wack = 0;
                end
            end
            if (rsp_pre && rsp_ready) begin
                m_rsp = 0; m_busy = 0;
            end
            if (ready_pre && req_valid) begin
                if (req_write) begin
                    ref_mem[req_addr] = req_wdata;
                    exp_we = 1; exp_waddr = req_addr; exp_wdata = req_wdata;
`ifdef REGFILE_REQUESTER_WRITE_ACK_EN
                    m_busy = 1; m_rsp = 1; m_data = req_wdata; m_wack = 1;
`endif
                end else begin
                    m_busy = 1; exp_raddr = req_addr; m_cnt = LAT;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (m_live) begin
            chk("req_ready", 32'(req_ready), 32'(!m_busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
            if (m_rsp) begin
                chk("rsp_rdata", 32'(rsp_rdata), 32'(m_data));
                chk("rsp_write", 32'(rsp_write), 32'(m_wack));
            end
            chk("rf_write_en", 32'(rf_write_en), 32'(exp_we));
            chk("rf_write_address", 32'(rf_write_address), 32'(exp_waddr));
            chk("rf_write_data", 32'(rf_write_data), 32'(exp_wdata));
            chk("rf_read_address", 32'(rf_read_address), 32'(exp_raddr));
        end
    end

    task automatic accept_req();
        bit acc = 0;
        for (int i = 0; i < 30 && !acc; i++) begin
            @(negedge clock);
            acc = req_ready;
            @(posedge clock);
            #1;
        end
        req_valid = 0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1; req_write = 1; req_addr = a; req_wdata = d;
        accept_req();
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int hold,
                           output logic [DW-1:0] data, output int lat, output logic wr);
        bit found = 0;
        rsp_ready = (hold == 0);
        req_valid = 1; req_write = 0; req_addr = a;
        accept_req();
        lat = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (rsp_valid) found = 1;
            else lat++;
        end
        if (!found) chk("rsp_timeout", 0, 1);
        data = rsp_rdata;
        wr   = rsp_write;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_data", 32'(rsp_rdata), 32'(data));
            chk("bp_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [DW-1:0] d;
        int            lat;
        logic          wr;
        logic [DW-1:0] exp_b2b [4];
        exp_b2b[0] = 8'h11; exp_b2b[1] = 8'h22; exp_b2b[2] = 8'h33; exp_b2b[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            rf_mem[i] = '0;
            ref_mem[i] = '0;
        end
        rf_read_data = '0;
        reset_n = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_rsp_rdata", 32'(rsp_rdata), 0);
        reset_n = 1;

        // Reset during an outstanding read.
        do_write(2'd3, 8'h99);
        req_valid = 1; req_write = 0; req_addr = 2'd2;
        accept_req();
        @(posedge clock);
        #1;
        reset_n = 0;
        @(posedge clock);
        #1;
        chk("rst_we", 32'(rf_write_en), 0);
        chk("rst_waddr", 32'(rf_write_address), 0);
        chk("rst_wdata", 32'(rf_write_data), 0);
        chk("rst_raddr", 32'(rf_read_address), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        reset_n = 1;
        @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 1);
        repeat (3) @(posedge clock);
        #1;
        chk("rst_no_rsp", 32'(rsp_valid), 0);

        // Back-to-back writes then read-back.
        do_write(2'd0, 8'h11);
        do_write(2'd1, 8'h22);
        do_write(2'd2, 8'h33);
        do_write(2'd3, 8'h44);
        for (int i = 0; i < 4; i++) begin
            do_read(AW'(i), 0, d, lat, wr);
            chk("b2b_read", 32'(d), 32'(exp_b2b[i]));
        end

        // Latency of a read with the consumer always ready.
        do_read(2'd3, 0, d, lat, wr);
        chk("lat_data", 32'(d), 32'h44);
        chk("lat_edges", 32'(lat), 32'(LAT));
        chk("lat_rsp_write", 32'(wr), 0);

        // Backpressure on the response.
        do_read(2'd1, 5, d, lat, wr);
        chk("bp_read", 32'(d), 32'h22);

        // Read immediately after write to the same address.
        do_write(2'd2, 8'hA5);
        do_read(2'd2, 0, d, lat, wr);
        chk("raw_read", 32'(d), 32'hA5);

`ifdef REGFILE_REQUESTER_WRITE_ACK_EN
        rsp_ready = 0;
        do_write(2'd1, 8'h5A);
        @(negedge clock);
        chk("ack_valid", 32'(rsp_valid), 1);
        chk("ack_write", 32'(rsp_write), 1);
        chk("ack_data", 32'(rsp_rdata), 32'h5A);
        req_valid = 1; req_write = 1; req_addr = 2'd2; req_wdata = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("ack_block", 32'(req_ready), 0);
        end
        @(posedge clock);
        #1;
        rsp_ready = 1;
        accept_req();
        repeat (2) @(posedge clock);
        #1;
        do_read(2'd1, 0, d, lat, wr);
        chk("ack_read_data", 32'(d), 32'h5A);
        chk("ack_read_write", 32'(wr), 0);
`endif

        repeat (3) @(posedge clock);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_requester.md
Name: regfile_requester

Overview:
- Initiator for the team's 2-port, 4-entry register file. Converts a valid/ready request stream (read or write) into register-file port activity and returns read data on a valid/ready response stream.
- Sits between a command source (host/CPU shim) and the register file. It owns the write port and read-address port and samples read data at the right cycle.

Parameters:
- ADDR_W, 2, register-file address width.
- DATA_W, 8, register-file data width.
- RD_LAT, 2, clock edges from rf_read_address change until rf_read_data is valid and sampled; must be >= 1.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when req_valid is also high.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  target register.
- req_wdata  input  DATA_W  write data, ignored for reads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumer ready.
- rsp_rdata  output  DATA_W  response data.
- rsp_write  output  1  response is a write acknowledge; always 0 unless the optional feature is compiled in.
- rf_write_address  output  ADDR_W  to register-file write address.
- rf_write_data  output  DATA_W  to register-file write data.
- rf_write_en  output  1  to register-file write enable.
- rf_read_address  output  ADDR_W  to register-file read address.
- rf_read_data  input  DATA_W  from register-file read data.

Behaviour:
- Reset (reset_n sampled 0 at an edge):
  - state = IDLE; rsp_valid = 0; rsp_rdata = 0; rsp_write = 0.
  - rf_write_en = 0; rf_write_address = 0; rf_write_data = 0; rf_read_address = 0; wait counter = 0.
  - An in-flight read is dropped and produces no response.
- req_ready = 1 only in IDLE; it is combinational from state. Acceptance is req_valid & req_ready at an edge.
- All rf_* outputs and all rsp_* outputs are registered.
- State machine IDLE / RD_WAIT / RSP:
  - IDLE, write accepted: rf_write_address <= req_addr; rf_write_data <= req_wdata; rf_write_en <= 1. State stays IDLE, so back-to-back writes run one per cycle.
  - IDLE, read accepted: rf_read_address <= req_addr; counter <= RD_LAT-1; next state RD_WAIT.
  - RD_WAIT: the counter decrements each edge. At the edge where counter == 0: rsp_rdata <= rf_read_data, rsp_valid <= 1, next state RSP.
  - RSP: rsp_valid and rsp_rdata are held stable until rsp_valid & rsp_ready at an edge. On that edge: rsp_valid <= 0, next state IDLE. The next request can be accepted on the following cycle.
- rf_write_en is high for exactly one cycle per accepted write and is 0 in any cycle with no write accepted at the previous edge.
- rf_read_address holds its last value between reads. rf_write_address and rf_write_data hold their last values when rf_write_en is 0.
- Read latency with RD_LAT=2: accept at edge E0, rsp_valid high after E2. The minimum read-to-read period is 4 cycles when rsp_ready is tied high.
- Write then read of the same address, back to back, returns the new data: the write commits at E1 and the read address registers at E2.
- No arithmetic other than the wait counter, which is sized clog2(RD_LAT)+1 and never wraps.

Optional Feature:
- Macro: REGFILE_REQUESTER_WRITE_ACK_EN.
- Defined:
  - An accepted write also moves to RSP, with rsp_valid <= 1, rsp_write <= 1, rsp_rdata <= req_wdata at the accept edge.
  - req_ready stays low until that acknowledge is consumed, so writes are no longer back-to-back.
  - A read response drives rsp_write = 0.
- Undefined: writes generate no response, and rsp_write is tied 0.

Decomposition:
- Package regfile_pkg holds:
  - the state enum (IDLE, RD_WAIT, RSP);
  - default constants RF_ADDR_W = 2, RF_DATA_W = 8, RF_RD_LAT = 2.
- Single module; no sub-module is warranted. The response slot is one register set inside the FSM.

Test Plan:
- Reset mid-read: accept read addr 2, assert reset_n=0 before rsp_valid -> rsp_valid stays 0; all rf_* outputs are 0 after the reset edge; req_ready=1 once reset_n=1.
- Back-to-back writes: writes (0,0x11), (1,0x22), (2,0x33), (3,0x44) on consecutive cycles -> rf_write_en high for 4 consecutive cycles with matching address/data; reads of 0..3 return 0x11, 0x22, 0x33, 0x44.
- Read latency: with rsp_ready=1, read addr 3 (holding 0x44) accepted at E0 -> rsp_valid high exactly after E2 with rsp_rdata=0x44; req_ready low from E0 until after the response handshake.
- Response backpressure: rsp_ready=0 for 5 cycles on a read of addr 1 -> rsp_valid and rsp_rdata=0x22 are stable, req_ready=0; the response is released on the first rsp_ready=1.
- Read-after-write hazard: write (2,0xA5), then read 2 on the next cycle -> rsp_rdata=0xA5.
- Macro defined: write (1,0x5A) -> rsp_valid with rsp_write=1, rsp_rdata=0x5A; a second write is not accepted until the acknowledge handshake; a subsequent read gives rsp_write=0, rsp_rdata=0x5A.
